// File: rtl/ll_window_detector.sv
// ll_window_detector
// Sliding-window sum of line-length samples with hysteretic threshold detect.
//
// state | meaning
// ------+-----------------------------------------------------------------
// FILL  | window not yet full; outgoing term forced to 0, no sum_valid
// RUN   | window full; each sample replaces the oldest entry, sum_valid pulses
module ll_window_detector #(
  parameter int input_width = 33,
  parameter int WIN_LEN     = 16,
  parameter int LOG2_WIN    = 4,
  parameter int HOLD        = 3
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [input_width-1:0]          din,
  input  logic                            data_valid,
  input  logic [input_width+LOG2_WIN-1:0] thresh,
  output logic [input_width+LOG2_WIN-1:0] win_sum,
  output logic                            sum_valid,
  output logic                            detect,
  output logic                            err
);

  localparam int SW  = input_width + LOG2_WIN;
  localparam int HCW = (HOLD < 2) ? 1 : $clog2(HOLD);
  localparam logic [LOG2_WIN-1:0] CNT_LAST = LOG2_WIN'(WIN_LEN - 1);
  localparam logic [HCW-1:0]      HC_LAST  = HCW'(HOLD - 1);

  typedef enum logic {FILL, RUN} state_t;

  state_t                 state;
  logic [input_width-1:0] mem [WIN_LEN];
  logic [LOG2_WIN-1:0]    wr_ptr;
  logic [LOG2_WIN-1:0]    cnt;
  logic [HCW-1:0]         hcnt;

  logic [input_width-1:0] sample;
  logic [SW-1:0]          add_term;
  logic [SW-1:0]          sub_term;
  logic                   exceed;

  // Negative samples are clamped to zero; the stored entry is the clamped value.
  always_comb begin
    sample   = din[input_width-1] ? '0 : din;
    add_term = SW'(sample);
    sub_term = (state == RUN) ? SW'(mem[wr_ptr]) : '0;
    exceed   = (win_sum > thresh);
  end

  // Circular sample buffer; never cleared, FILL masks stale entries.
  always_ff @(posedge clk) begin
    if (!rst && data_valid) mem[wr_ptr] <= sample;
  end

  // Window FSM: pointer, fill count, running sum and the sum_valid pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FILL;
      wr_ptr    <= '0;
      cnt       <= '0;
      win_sum   <= '0;
      sum_valid <= 1'b0;
    end else begin
      sum_valid <= 1'b0;
      if (data_valid) begin
        win_sum <= win_sum + add_term - sub_term;
        wr_ptr  <= wr_ptr + 1'b1;
        case (state)
          FILL: begin
            cnt <= cnt + 1'b1;
            if (cnt == CNT_LAST) begin
              state     <= RUN;
              sum_valid <= 1'b1;
            end
          end
          RUN: sum_valid <= 1'b1;
          default: state <= FILL;
        endcase
      end
    end
  end

  // Hysteresis: HOLD consecutive opposing windows flip detect, evaluated the cycle after sum_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt   <= '0;
      detect <= 1'b0;
    end else if (sum_valid) begin
      if (exceed != detect) begin
        if (hcnt == HC_LAST) begin
          detect <= ~detect;
          hcnt   <= '0;
        end else begin
          hcnt <= hcnt + 1'b1;
        end
      end else begin
        hcnt <= '0;
      end
    end
  end

  // Sticky error on any valid negative sample.
  always_ff @(posedge clk) begin
    if (rst) err <= 1'b0;
    else if (data_valid && din[input_width-1]) err <= 1'b1;
  end

endmodule
